ercm8_share_ctrl: RTL and testbench
===================================

# ercm8_share_ctrl

Controller that shares one ERCM8 approximate 8×8 multiplier between two requesters. It arbitrates round-robin, applies a per-requester approximation mask, and holds operands stable for a programmable settle time, because the gate-level multiplier is combinational. It then captures the product and returns it on the requester's response channel. It sits between the two client datapaths and the multiplier netlist, so the SDF-annotated multiplier can be swapped in without touching the clients.

## Interface
Parameters:
- SETTLE, 2: cycles operands are held on the multiplier before capture; legal range 1..15.
- DW, 8: operand width; product width is 2*DW.
- MW, 7: mask width.

Ports (clock and reset first):
- clk  in  1  single clock; one clock domain; reset is synchronous and active-high.
- rst  in  1  synchronous, active-high reset.
- cfg_we  in  1  mask register write strobe.
- cfg_sel  in  1  target requester for the mask write (0/1).
- cfg_mask  in  MW  mask value to write.
- req0_valid, req1_valid  in  1  operation request.
- req0_ready, req1_ready  out  1  request accepted this cycle.
- req0_a, req0_b, req1_a, req1_b  in  DW  operands.
- rsp0_valid, rsp1_valid  out  1  product available.
- rsp0_ready, rsp1_ready  in  1  consumer takes the product.
- rsp0_p, rsp1_p  out  2*DW  product.
- mul_a, mul_b  out  DW  operands to the multiplier (dat_in_a/dat_in_b).
- mul_mask  out  MW  mask to the multiplier.
- mul_p  in  2*DW  multiplier output (dat_o).
- busy  out  1  high whenever the state is not IDLE.

## Operation
- States: IDLE → HOLD → RESP → IDLE.
- **IDLE**
  - Grant is combinational from valids and the round-robin pointer `last`.
  - Only one valid: that requester is granted.
  - Both valid: the requester ≠ `last` is granted.
  - reqN_ready = (state==IDLE) & grant==N. At most one ready is high.
  - On handshake: latch a, b, the requester's mask register, and the source id into the op register; set `last`=id; clear the settle counter; go to HOLD.
- **HOLD**
  - mul_a/mul_b/mul_mask are driven from the op register and stay constant.
  - The counter increments each cycle. When counter==SETTLE-1, capture mul_p into the result register and go to RESP.
- **RESP**
  - rspN_valid is high for the latched id only. rspN_p = the result register, stable until handshake.
  - On rspN_ready, go to IDLE. A new request is not accepted in the same cycle.
- **Mask registers** (mask0, mask1):
  - Written on cfg_we in any state.
  - A write during HOLD/RESP does not affect the in-flight op, because the mask was latched at accept.
  - A write in the same cycle as an accept: the op uses the old value; the new value applies to the next op.
- The other requester's rsp_valid stays 0. Requesters whose valid stays high while not granted simply wait; no request is dropped.
- The op register stays driving mul_* in IDLE (last op's values), so the multiplier inputs do not toggle needlessly.

## Timing
- Reset values: state=IDLE, last=1 (so req0 wins the first tie), mask0=mask1=0, op/result registers=0.
- Outputs after reset: all outputs 0, including mul_a, mul_b, mul_mask, busy, both ready* (until valid arrives), and both rsp*.
- Accept at cycle t:
  - mul_* change at t+1.
  - mul_p is sampled at the end of cycle t+SETTLE.
  - rsp_valid is high from t+SETTLE+1.
  - Minimum accept-to-accept interval is SETTLE+2 cycles with rsp_ready tied high.
- rst asserted mid-HOLD or mid-RESP: next cycle is IDLE with reset values. The in-flight op is discarded, with no response.
- rsp_ready ignored unless in RESP for that id.

## Structure
Shared package ercm_pkg holds:
- DW/MW defaults.
- The state enum (IDLE, HOLD, RESP).
- The product width constant.

One sub-module is natural: ercm_rr_arb, the 2-way round-robin grant with the `last` pointer and update-on-accept. The multiplier itself stays outside this block.

## Test plan
The bench uses an exact-product multiplier stub that ignores mask and asserts mul_* stable throughout HOLD.
- Reset then req0 a=13, b=11, SETTLE=2 → req0_ready at t, rsp0_valid at t+3, rsp0_p=143, rsp1_valid stays 0.
- Both valid from reset, req0 (255,255), req1 (2,3) → req0 served first (65025), then req1 (6), then req0 again if still valid.
- rsp0_ready held low 5 cycles → rsp0_valid and rsp0_p=143 held; busy=1; req1_ready=0 throughout.
- cfg_we sel=1 mask=7'h55 in the accept cycle of req1 → mul_mask=old 0 for that op; the next req1 op drives 7'h55.
- rst asserted during HOLD → next cycle busy=0, no response issued, next req0 grant behaves as after reset.
- SETTLE=1 with back-to-back valid and rsp_ready=1 → accepts every 3 cycles, alternating requesters.

Source files
------------

// File: rtl/ercm_pkg.sv
// Shared definitions for the ERCM8 multiplier share controller:
// default widths and the controller state encoding.
package ercm_pkg;

    localparam int DW_DEF = 8;
    localparam int MW_DEF = 7;
    localparam int PW_DEF = 2 * DW_DEF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/ercm_rr_arb.sv
// Two-way round-robin grant. The pointer records the last requester served
// and only moves when a grant is actually accepted.
module ercm_rr_arb (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic valid0,
    input  logic valid1,
    input  logic accept,
    output logic grant_valid,
    output logic grant_id
);

    logic last;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            last <= 1'b1;
        end else if (accept) begin
            last <= grant_id;
        end
    end

    // NOTE: every output gets a default first so no latch is inferred.
    always_comb begin
        grant_id = 1'b0;
        if (valid0 && valid1) begin
            grant_id = ~last;
        end else if (valid1) begin
            grant_id = 1'b1;
        end
        grant_valid = enable & (valid0 | valid1);
    end

endmodule

// File: rtl/ercm8_share_ctrl.sv
// Shares one combinational ERCM8 multiplier between two requesters: round-robin
// accept, hold operands for SETTLE cycles, capture the product, respond.
module ercm8_share_ctrl
    import ercm_pkg::*;
#(
    parameter int SETTLE = 2,
    parameter int DW     = DW_DEF,
    parameter int MW     = MW_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cfg_we,
    input  logic            cfg_sel,
    input  logic [MW-1:0]   cfg_mask,
    input  logic            req0_valid,
    output logic            req0_ready,
    input  logic [DW-1:0]   req0_a,
    input  logic [DW-1:0]   req0_b,
    input  logic            req1_valid,
    output logic            req1_ready,
    input  logic [DW-1:0]   req1_a,
    input  logic [DW-1:0]   req1_b,
    output logic            rsp0_valid,
    input  logic            rsp0_ready,
    output logic [2*DW-1:0] rsp0_p,
    output logic            rsp1_valid,
    input  logic            rsp1_ready,
    output logic [2*DW-1:0] rsp1_p,
    output logic [DW-1:0]   mul_a,
    output logic [DW-1:0]   mul_b,
    output logic [MW-1:0]   mul_mask,
    input  logic [2*DW-1:0] mul_p,
    output logic            busy
);

    localparam logic [3:0] LAST_CNT = 4'(SETTLE - 1);

    state_t          state, state_nxt;
    logic [DW-1:0]   op_a, op_b;
    logic [MW-1:0]   op_mask;
    logic            op_id;
    logic [3:0]      cnt;
    logic [2*DW-1:0] result;
    logic [MW-1:0]   mask0, mask1;
    logic            grant_valid, grant_id, accept, settle_done;

    ercm_rr_arb u_arb (
        .clk        (clk),
        .rst        (rst),
        .enable     (state == ST_IDLE),
        .valid0     (req0_valid),
        .valid1     (req1_valid),
        .accept     (accept),
        .grant_valid(grant_valid),
        .grant_id   (grant_id)
    );

    assign req0_ready  = grant_valid & ~grant_id;
    assign req1_ready  = grant_valid & grant_id;
    assign accept      = (req0_ready & req0_valid) | (req1_ready & req1_valid);
    assign settle_done = (state == ST_HOLD) && (cnt == LAST_CNT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        rsp0_valid = 1'b0;
        rsp1_valid = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (accept) state_nxt = ST_HOLD;
            end
            ST_HOLD: begin
                if (settle_done) state_nxt = ST_RESP;
            end
            ST_RESP: begin
                rsp0_valid = ~op_id;
                rsp1_valid = op_id;
                if (op_id ? rsp1_ready : rsp0_ready) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // NOTE: the mask registers are small configuration state and are reset; they are not a memory array.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_a    <= '0;
            op_b    <= '0;
            op_mask <= '0;
            op_id   <= 1'b0;
            cnt     <= '0;
            result  <= '0;
            mask0   <= '0;
            mask1   <= '0;
        end else begin
            // The op latches the mask value from before any same-cycle cfg write.
            if (accept) begin
                op_a    <= grant_id ? req1_a : req0_a;
                op_b    <= grant_id ? req1_b : req0_b;
                op_mask <= grant_id ? mask1 : mask0;
                op_id   <= grant_id;
                cnt     <= '0;
            end else if (state == ST_HOLD) begin
                cnt <= cnt + 4'd1;
            end
            if (settle_done) begin
                result <= mul_p;
            end
            if (cfg_we && !cfg_sel) mask0 <= cfg_mask;
            if (cfg_we && cfg_sel)  mask1 <= cfg_mask;
        end
    end

    // The op register keeps driving the multiplier while idle to avoid toggling it.
    assign mul_a    = op_a;
    assign mul_b    = op_b;
    assign mul_mask = op_mask;
    assign rsp0_p   = result;
    assign rsp1_p   = result;
    assign busy     = (state != ST_IDLE);

endmodule

// File: tb/tb_ercm8_share_ctrl.sv
// Bench for ercm8_share_ctrl: transaction-timing reference model with directed
// and random stimulus, plus a SETTLE=1 instance for back-to-back throughput.
module tb_ercm8_share_ctrl;

    localparam int S  = 2;
    localparam int DW = 8;
    localparam int MW = 7;
    localparam int PW = 2 * DW;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, cfg_we, cfg_sel;
    logic [MW-1:0] cfg_mask;
    logic          req0_valid, req0_ready, req1_valid, req1_ready;
    logic [DW-1:0] req0_a, req0_b, req1_a, req1_b;
    logic          rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
    logic [PW-1:0] rsp0_p, rsp1_p, mul_p;
    logic [DW-1:0] mul_a, mul_b;
    logic [MW-1:0] mul_mask;
    logic          busy;

    // Exact-product multiplier stub; the mask is ignored.
    assign mul_p = PW'(mul_a) * PW'(mul_b);

    ercm8_share_ctrl #(.SETTLE(S), .DW(DW), .MW(MW)) u_dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_mask(cfg_mask),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_p(rsp0_p),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_p(rsp1_p),
        .mul_a(mul_a), .mul_b(mul_b), .mul_mask(mul_mask), .mul_p(mul_p), .busy(busy)
    );

    // Second instance with SETTLE=1 for the throughput test.
    logic          s1_rst, s1_v0, s1_r0, s1_v1, s1_r1, s1_rv0, s1_rv1, s1_busy;
    logic [PW-1:0] s1_p0, s1_p1, s1_mul_p;
    logic [DW-1:0] s1_mul_a, s1_mul_b;
    logic [MW-1:0] s1_mul_mask;

    assign s1_mul_p = PW'(s1_mul_a) * PW'(s1_mul_b);

    ercm8_share_ctrl #(.SETTLE(1), .DW(DW), .MW(MW)) u_dut_s1 (
        .clk(clk), .rst(s1_rst), .cfg_we(1'b0), .cfg_sel(1'b0), .cfg_mask('0),
        .req0_valid(s1_v0), .req0_ready(s1_r0), .req0_a(8'd5), .req0_b(8'd7),
        .req1_valid(s1_v1), .req1_ready(s1_r1), .req1_a(8'd9), .req1_b(8'd4),
        .rsp0_valid(s1_rv0), .rsp0_ready(1'b1), .rsp0_p(s1_p0),
        .rsp1_valid(s1_rv1), .rsp1_ready(1'b1), .rsp1_p(s1_p1),
        .mul_a(s1_mul_a), .mul_b(s1_mul_b), .mul_mask(s1_mul_mask), .mul_p(s1_mul_p),
        .busy(s1_busy)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    // Reference model: one outstanding op, response due SETTLE+1 cycles after accept.
    bit            m_active;
    int            m_tacc;
    logic [DW-1:0] m_a, m_b;
    logic [MW-1:0] m_mask;
    bit            m_id;
    bit            m_last;
    logic [MW-1:0] m_mreg [2];

    task automatic model_reset();
        m_active = 0; m_tacc = 0; m_a = '0; m_b = '0; m_mask = '0; m_id = 0;
        m_last = 1; m_mreg[0] = '0; m_mreg[1] = '0;
    endtask

    // Check the current cycle's outputs, advance the model across the edge, go to the next negedge.
    task automatic step();
        bit idle, in_resp, e_r0, e_r1, e_v0, e_v1;
        #1;
        idle    = !m_active;
        in_resp = m_active && (cyc >= m_tacc + S + 1);
        e_r0    = idle && req0_valid && (!req1_valid || m_last);
        e_r1    = idle && req1_valid && (!req0_valid || !m_last);
        e_v0    = in_resp && !m_id;
        e_v1    = in_resp && m_id;
        check("req0_ready", 32'(req0_ready), 32'(e_r0));
        check("req1_ready", 32'(req1_ready), 32'(e_r1));
        check("busy", 32'(busy), 32'(m_active));
        check("rsp0_valid", 32'(rsp0_valid), 32'(e_v0));
        check("rsp1_valid", 32'(rsp1_valid), 32'(e_v1));
        check("mul_a", 32'(mul_a), 32'(m_a));
        check("mul_b", 32'(mul_b), 32'(m_b));
        check("mul_mask", 32'(mul_mask), 32'(m_mask));
        if (e_v0) check("rsp0_p", 32'(rsp0_p), 32'(m_a) * 32'(m_b));
        if (e_v1) check("rsp1_p", 32'(rsp1_p), 32'(m_a) * 32'(m_b));
        if (rst) begin
            model_reset();
        end else begin
            if ((e_r0 && req0_valid) || (e_r1 && req1_valid)) begin
                m_id     = e_r1;
                m_a      = e_r1 ? req1_a : req0_a;
                m_b      = e_r1 ? req1_b : req0_b;
                m_mask   = m_mreg[e_r1];
                m_last   = e_r1;
                m_active = 1;
                m_tacc   = cyc;
            end else if (in_resp && (m_id ? rsp1_ready : rsp0_ready)) begin
                m_active = 0;
            end
            if (cfg_we) m_mreg[cfg_sel] = cfg_mask;
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic quiet_inputs();
        rst = 0; cfg_we = 0; cfg_sel = 0; cfg_mask = '0;
        req0_valid = 0; req1_valid = 0; rsp0_ready = 1; rsp1_ready = 1;
    endtask

    task automatic wait_idle();
        quiet_inputs();
        for (int i = 0; i < 40 && m_active; i++) step();
        check("wait_idle", 32'(busy), 32'd0);
    endtask

    int acc_cyc [$];
    bit acc_id  [$];

    initial begin
        quiet_inputs();
        req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
        rst = 1; s1_rst = 1; s1_v0 = 0; s1_v1 = 0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 0;
        check("rsp0_p_rst", 32'(rsp0_p), 32'd0);
        check("rsp1_p_rst", 32'(rsp1_p), 32'd0);
        step();

        // Single req0 13*11 straight after reset.
        req0_valid = 1; req0_a = 8'd13; req0_b = 8'd11;
        step();
        req0_valid = 0;
        repeat (4) step();

        // Both valid from reset: req0 wins first, then alternation.
        rst = 1; step(); rst = 0;
        req0_valid = 1; req0_a = 8'd255; req0_b = 8'd255;
        req1_valid = 1; req1_a = 8'd2;   req1_b = 8'd3;
        repeat (14) step();
        wait_idle();

        // Consumer stalls rsp0 for several cycles while req1 waits.
        req0_valid = 1; req0_a = 8'd13; req0_b = 8'd11; rsp0_ready = 0;
        step();
        req0_valid = 0; req1_valid = 1; req1_a = 8'd7; req1_b = 8'd9;
        repeat (8) step();
        rsp0_ready = 1;
        repeat (6) step();
        wait_idle();

        // Mask write to requester 1 in the same cycle as its accept.
        req1_valid = 1; req1_a = 8'd3; req1_b = 8'd5;
        cfg_we = 1; cfg_sel = 1; cfg_mask = 7'h55;
        step();
        cfg_we = 0; req1_valid = 0;
        check("mask_old_used", 32'(mul_mask), 32'd0);
        repeat (4) step();
        req1_valid = 1; req1_a = 8'd6; req1_b = 8'd6;
        step();
        req1_valid = 0;
        check("mask_new_used", 32'(mul_mask), 32'h55);
        repeat (4) step();
        wait_idle();

        // Reset mid-HOLD discards the op; the next tie goes to req0 again.
        req0_valid = 1; req0_a = 8'd200; req0_b = 8'd3;
        step();
        req0_valid = 0; rst = 1;
        step();
        rst = 0;
        step();
        req0_valid = 1; req1_valid = 1; req0_a = 8'd4; req0_b = 8'd4;
        step();
        req0_valid = 0; req1_valid = 0;
        repeat (5) step();

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            rst        = ($urandom_range(0, 99) == 0);
            req0_valid = $urandom_range(0, 1);
            req1_valid = $urandom_range(0, 1);
            req0_a     = DW'($urandom); req0_b = DW'($urandom);
            req1_a     = DW'($urandom); req1_b = DW'($urandom);
            rsp0_ready = ($urandom_range(0, 3) != 0);
            rsp1_ready = ($urandom_range(0, 3) != 0);
            cfg_we     = ($urandom_range(0, 5) == 0);
            cfg_sel    = $urandom_range(0, 1);
            cfg_mask   = MW'($urandom);
            step();
        end
        wait_idle();

        // SETTLE=1, both requesters always valid, consumers always ready.
        s1_rst = 0; s1_v0 = 1; s1_v1 = 1;
        for (int c = 0; c < 24; c++) begin
            #1;
            if (s1_r0 || s1_r1) begin
                acc_cyc.push_back(c);
                acc_id.push_back(s1_r1);
            end
            if (s1_rv0) check("s1_rsp0_p", 32'(s1_p0), 32'd35);
            if (s1_rv1) check("s1_rsp1_p", 32'(s1_p1), 32'd36);
            @(negedge clk);
        end
        check("s1_accepts", 32'(acc_cyc.size() >= 7), 32'd1);
        if (acc_id.size() > 0) check("s1_first_id", 32'(acc_id[0]), 32'd0);
        for (int k = 1; k < acc_cyc.size(); k++) begin
            check("s1_interval", 32'(acc_cyc[k] - acc_cyc[k-1]), 32'd3);
            check("s1_alternate", 32'(acc_id[k]), 32'(!acc_id[k-1]));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
